// File: rtl/upctr_sched_pkg.sv
// Shared types and constants for the upctr_sched round-robin step scheduler.
// Optional CLEAR/HOLD opcodes are enabled by defining UPCTR_SCHED_CLEAR_EN.
package upctr_sched_pkg;

  typedef enum logic [1:0] {
    OP_INC   = 2'b00,
    OP_ROL   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_HOLD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/upctr_sched_if.sv
// Command handshakes for both requesters plus the completion pulse.
// The master side issues commands; the slave side is the scheduler.
interface upctr_sched_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             a_valid;
  logic [1:0]       a_op;
  logic [CNT_W-1:0] a_cnt;
  logic             a_ready;

  logic             b_valid;
  logic [1:0]       b_op;
  logic [CNT_W-1:0] b_cnt;
  logic             b_ready;

  logic             done_valid;
  logic             done_id;
  logic [WIDTH-1:0] done_value;

  modport master (
    output a_valid, a_op, a_cnt,
    output b_valid, b_op, b_cnt,
    input  a_ready, b_ready,
    input  done_valid, done_id, done_value
  );

  modport slave (
    input  a_valid, a_op, a_cnt,
    input  b_valid, b_op, b_cnt,
    output a_ready, b_ready,
    output done_valid, done_id, done_value
  );

endinterface

// File: rtl/upctr_step.sv
// Combinational single-step datapath: INC/ROL, plus CLEAR/HOLD when
// UPCTR_SCHED_CLEAR_EN is defined (otherwise only op[0] is decoded).
module upctr_step
  import upctr_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value
);

`ifdef UPCTR_SCHED_CLEAR_EN
  always_comb begin
    next_value = value;
    unique case (op)
      OP_INC:   next_value = value + WIDTH'(1);
      OP_ROL:   next_value = {value[WIDTH-2:0], value[WIDTH-1]};
      OP_CLEAR: next_value = '0;
      OP_HOLD:  next_value = value;
      default:  next_value = value;
    endcase
  end
`else
  // op[1] is deliberately ignored in this build
  logic unused_op_hi;
  assign unused_op_hi = op[1];

  always_comb begin
    next_value = value + WIDTH'(1);
    if (op[0]) next_value = {value[WIDTH-2:0], value[WIDTH-1]};
  end
`endif

endmodule

// File: rtl/upctr_sched.sv
// Round-robin scheduler sharing one increment/rotate datapath between two
// requesters. UPCTR_SCHED_CLEAR_EN adds the CLEAR and HOLD opcodes.
module upctr_sched
  import upctr_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  upctr_sched_if.slave     bus,
  output logic [WIDTH-1:0] value,
  output logic             busy
);

  state_e           state, state_n;
  op_e              op_q;
  op_e              acc_op;
  logic             id_q;
  logic             last_grant;
  logic             idle;
  logic             accept;
  logic             acc_id;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] load_cnt;
  logic [WIDTH-1:0] step_value;

  assign idle = (state == IDLE);

  // On contention the requester that was not granted last wins
  assign bus.a_ready = idle & bus.a_valid & (~bus.b_valid | (last_grant == REQ_B));
  assign bus.b_ready = idle & bus.b_valid & (~bus.a_valid | (last_grant == REQ_A));

  assign accept  = (bus.a_valid & bus.a_ready) | (bus.b_valid & bus.b_ready);
  assign acc_id  = bus.b_ready ? REQ_B : REQ_A;
  assign acc_op  = op_e'(bus.b_ready ? bus.b_op : bus.a_op);
  assign acc_cnt = bus.b_ready ? bus.b_cnt : bus.a_cnt;

`ifdef UPCTR_SCHED_CLEAR_EN
  assign load_cnt = (acc_op == OP_CLEAR) ? CNT_W'(1) : acc_cnt;
`else
  assign load_cnt = acc_cnt;
`endif

  upctr_step #(.WIDTH(WIDTH)) u_step (
    .op         (op_q),
    .value      (value),
    .next_value (step_value)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = (load_cnt != '0) ? RUN : DONE;
      RUN:     if (remaining == CNT_W'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value          <= '0;
      remaining      <= '0;
      op_q           <= OP_INC;
      id_q           <= REQ_A;
      last_grant     <= REQ_B;
      busy           <= 1'b0;
      bus.done_valid <= 1'b0;
      bus.done_id    <= REQ_A;
      bus.done_value <= '0;
    end else begin
      busy           <= (state_n != IDLE);
      bus.done_valid <= (state == DONE);
      if (state == DONE) begin
        bus.done_id    <= id_q;
        bus.done_value <= value;
      end
      if (idle && accept) begin
        op_q       <= acc_op;
        id_q       <= acc_id;
        remaining  <= load_cnt;
        last_grant <= acc_id;
      end
      if (state == RUN) begin
        value     <= step_value;
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_upctr_sched.sv
// Directed self-checking bench for upctr_sched; inputs driven and outputs
// sampled around the falling clock edge. Honours UPCTR_SCHED_CLEAR_EN.
module tb_upctr_sched;

  logic       clk;
  logic       rst;
  logic [7:0] value;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  upctr_sched_if #(.WIDTH(8), .CNT_W(4)) bus ();

  upctr_sched #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .value (value),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs one command to completion without checking anything; starts and ends at a negedge in IDLE
  task automatic issue_cmd(input logic id, input logic [1:0] op, input logic [3:0] cnt);
    if (id) begin
      bus.b_valid = 1'b1; bus.b_op = op; bus.b_cnt = cnt;
    end else begin
      bus.a_valid = 1'b1; bus.a_op = op; bus.a_cnt = cnt;
    end
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (int'(cnt) + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (value !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL reset_value: got %h expected 00", value);
    end
    tests_run++;
    if ({busy, bus.done_valid, bus.done_id, bus.done_value} !== 11'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: busy=%b done_valid=%b done_id=%b done_value=%h expected all 0",
               busy, bus.done_valid, bus.done_id, bus.done_value);
    end
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #1;
    tests_run++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 10", {bus.a_ready, bus.b_ready});
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_inc_basic();
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_cnt = 4'd3;
    #1;
    tests_run++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL inc_ready: got %b expected 10", {bus.a_ready, bus.b_ready});
    end
    @(negedge clk);
    bus.a_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || value !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL inc_accept: busy=%b value=%h expected busy=1 value=00", busy, value);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (value !== 8'(k) || bus.done_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL inc_step%0d: value=%h done_valid=%b expected value=%h done_valid=0",
                 k, value, bus.done_valid, 8'(k));
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus.done_valid !== 1'b1 || bus.done_id !== 1'b0 || bus.done_value !== 8'h03) begin
      tests_failed++;
      $display("[TB] FAIL inc_done: valid=%b id=%b value=%h expected 1 0 03",
               bus.done_valid, bus.done_id, bus.done_value);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL inc_done_width: done_valid=%b expected 0", bus.done_valid);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) issue_cmd(1'b0, 2'b00, 4'd15);
    issue_cmd(1'b0, 2'b00, 4'd4);
    issue_cmd(1'b0, 2'b01, 4'd1);
    tests_run++;
    if (value !== 8'hFE) begin
      tests_failed++; $display("[TB] FAIL wrap_setup: value=%h expected fe", value);
    end
    bus.b_valid = 1'b1; bus.b_op = 2'b00; bus.b_cnt = 4'd2;
    #1;
    tests_run++;
    if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
      tests_failed++; $display("[TB] FAIL wrap_ready: got %b expected 01", {bus.a_ready, bus.b_ready});
    end
    @(negedge clk);
    bus.b_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (value !== 8'hFF) begin
      tests_failed++; $display("[TB] FAIL wrap_step1: value=%h expected ff", value);
    end
    @(negedge clk);
    tests_run++;
    if (value !== 8'h00 || bus.done_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL wrap_step2: value=%h done_valid=%b expected 00 0", value, bus.done_valid);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done_valid !== 1'b1 || bus.done_id !== 1'b1 || bus.done_value !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL wrap_done: valid=%b id=%b value=%h expected 1 1 00",
               bus.done_valid, bus.done_id, bus.done_value);
    end
    @(negedge clk);
  endtask

  task automatic test_rol();
    issue_cmd(1'b0, 2'b00, 4'd3);
    issue_cmd(1'b0, 2'b01, 4'd7);
    tests_run++;
    if (value !== 8'h81) begin
      tests_failed++; $display("[TB] FAIL rol_setup: value=%h expected 81", value);
    end
    bus.a_valid = 1'b1; bus.a_op = 2'b01; bus.a_cnt = 4'd1;
    @(negedge clk);
    bus.a_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (value !== 8'h03 || bus.done_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rol_step: value=%h done_valid=%b expected 03 0", value, bus.done_valid);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done_valid !== 1'b1 || bus.done_id !== 1'b0 || bus.done_value !== 8'h03) begin
      tests_failed++;
      $display("[TB] FAIL rol_done: valid=%b id=%b value=%h expected 1 0 03",
               bus.done_valid, bus.done_id, bus.done_value);
    end
    @(negedge clk);
  endtask

  task automatic test_upper_ops();
`ifdef UPCTR_SCHED_CLEAR_EN
    issue_cmd(1'b1, 2'b11, 4'd3);
    tests_run++;
    if (value !== 8'h03) begin
      tests_failed++; $display("[TB] FAIL hold_value: value=%h expected 03", value);
    end
`else
    issue_cmd(1'b1, 2'b10, 4'd2);
    tests_run++;
    if (value !== 8'h05) begin
      tests_failed++; $display("[TB] FAIL alias_inc: value=%h expected 05", value);
    end
    issue_cmd(1'b0, 2'b11, 4'd1);
    tests_run++;
    if (value !== 8'h0A) begin
      tests_failed++; $display("[TB] FAIL alias_rol: value=%h expected 0a", value);
    end
`endif
  endtask

  task automatic test_contention();
    logic [1:0] exp_ready [7] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    logic       exp_done  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       exp_id    [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_val   [7] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02};
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_cnt = 4'd1;
    bus.b_valid = 1'b1; bus.b_op = 2'b00; bus.b_cnt = 4'd1;
    for (int i = 0; i < 7; i++) begin
      #1;
      tests_run++;
      if ({bus.a_ready, bus.b_ready} !== exp_ready[i] || bus.done_valid !== exp_done[i]) begin
        tests_failed++;
        $display("[TB] FAIL rr_cycle%0d: ready=%b done_valid=%b expected ready=%b done_valid=%b",
                 i, {bus.a_ready, bus.b_ready}, bus.done_valid, exp_ready[i], exp_done[i]);
      end
      if (exp_done[i]) begin
        tests_run++;
        if (bus.done_id !== exp_id[i] || bus.done_value !== exp_val[i]) begin
          tests_failed++;
          $display("[TB] FAIL rr_done%0d: id=%b value=%h expected id=%b value=%h",
                   i, bus.done_id, bus.done_value, exp_id[i], exp_val[i]);
        end
      end
      if (i == 6) begin
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_cnt();
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_cnt = 4'd0;
    @(negedge clk);
    bus.a_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || bus.done_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL zero_accept: busy=%b done_valid=%b expected 1 0", busy, bus.done_valid);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || bus.done_valid !== 1'b1 || bus.done_value !== 8'h02 || value !== 8'h02) begin
      tests_failed++;
      $display("[TB] FAIL zero_done: busy=%b done_valid=%b done_value=%h value=%h expected 0 1 02 02",
               busy, bus.done_valid, bus.done_value, value);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    logic saw_done = 1'b0;
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_cnt = 4'd10;
    @(negedge clk);
    bus.a_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (value !== 8'h06 || busy !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL midrun_before: value=%h busy=%b expected 06 1", value, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tests_run++;
    if (value !== 8'h00 || busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL midrun_reset: value=%h busy=%b expected 00 0", value, busy);
    end
    for (int i = 0; i < 15; i++) begin
      if (bus.done_valid === 1'b1 || value !== 8'h00) saw_done = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL midrun_dropped: activity seen=%b expected 0", saw_done);
    end
  endtask

`ifdef UPCTR_SCHED_CLEAR_EN
  task automatic test_clear();
    for (int i = 0; i < 5; i++) issue_cmd(1'b0, 2'b00, 4'd15);
    issue_cmd(1'b0, 2'b00, 4'd10);
    tests_run++;
    if (value !== 8'h55) begin
      tests_failed++; $display("[TB] FAIL clear_setup: value=%h expected 55", value);
    end
    bus.a_valid = 1'b1; bus.a_op = 2'b10; bus.a_cnt = 4'd7;
    @(negedge clk);
    bus.a_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (value !== 8'h00 || bus.done_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL clear_step: value=%h done_valid=%b expected 00 0", value, bus.done_valid);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done_valid !== 1'b1 || bus.done_value !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL clear_done: valid=%b value=%h expected 1 00", bus.done_valid, bus.done_value);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b0;
    bus.a_valid = 1'b0; bus.a_op = 2'b00; bus.a_cnt = 4'd0;
    bus.b_valid = 1'b0; bus.b_op = 2'b00; bus.b_cnt = 4'd0;
    test_reset();
    test_inc_basic();
    test_wrap();
    test_rol();
    test_upper_ops();
    test_contention();
    test_zero_cnt();
    test_reset_midrun();
`ifdef UPCTR_SCHED_CLEAR_EN
    test_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/upctr_sched.md
# upctr_sched

Round-robin scheduler that shares one 8-bit increment/rotate-left datapath between two requesters. It accepts step commands through valid/ready handshakes and sequences the datapath one step per cycle for the requested count. It returns a one-cycle completion pulse carrying the requester id and the resulting value. It sits between the command sources and the up-counter datapath and owns the datapath state register.

## Interface
Parameters:
- WIDTH, 8, datapath/state width
- CNT_W, 4, step-count field width (max 2^CNT_W-1 steps per command)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- a_valid  in  1  requester A command valid
- a_op  in  2  A opcode: 00 INC, 01 ROL, 1x see Configuration
- a_cnt  in  CNT_W  A step count
- a_ready  out  1  A command accepted this cycle when a_valid & a_ready
- b_valid / b_op / b_cnt / b_ready  same as A, for requester B
- done_valid  out  1  one-cycle completion pulse
- done_id  out  1  0 = A, 1 = B; valid with done_valid
- done_value  out  WIDTH  state after the command; valid with done_valid
- value  out  WIDTH  live datapath state
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Ready is offered to exactly one requester, chosen by the grant rule.
  - On valid & ready: latch op, cnt, id. Go to RUN if cnt != 0, otherwise go to DONE.
- Grant rule:
  - Only one valid requester: that one wins.
  - Both valid: the requester not granted last wins.
  - last_grant resets to B, so A wins the first contention.
  - last_grant updates only on acceptance.
- RUN:
  - Apply one step per cycle. INC: value = value + 1 mod 2^WIDTH (0xFF -> 0x00). ROL: value = {value[WIDTH-2:0], value[WIDTH-1]}.
  - Decrement the remaining count each cycle. Go to DONE after the step where remaining == 1.
- DONE:
  - Drive done_valid = 1, done_id = latched id, done_value = value.
  - Return to IDLE next cycle.
- No backpressure on done. The consumer must sample done_valid when it pulses.
- a_ready and b_ready are 0 in RUN and DONE. Requesters must hold their command stable until accepted.
- value is never modified in IDLE or DONE.
- Reset (rst = 0 at a clock edge), including mid-command:
  - FSM -> IDLE, value -> 0, last_grant -> B.
  - Any in-flight command is dropped with no done pulse.
- Reset values of outputs: a_ready and b_ready follow the IDLE grant rule (combinational from valid). done_valid = 0, done_id = 0, done_value = 0, value = 0, busy = 0.

## Timing
- Acceptance at edge T. value updates at edges T+1 through T+cnt.
- done_valid is high in the cycle after edge T+cnt+1. It is high for exactly one cycle, and done_value equals the final value in that cycle.
- cnt = 0: done_valid is high after edge T+1 with value unchanged.
- Next acceptance earliest at edge T+cnt+2, so the minimum issue interval is cnt+2 cycles.
- a_ready/b_ready are combinational from a_valid/b_valid, state and last_grant. All other outputs are registered.

## Configuration
- Macro UPCTR_SCHED_CLEAR_EN.
- Defined:
  - op 10 = CLEAR: one RUN cycle sets value to 0. cnt is ignored and treated as 1.
  - op 11 = HOLD: runs cnt cycles with value unchanged.
- Undefined:
  - op[1] is ignored and ops decode on op[0] only (1x behaves as INC/ROL per op[0]).
  - No CLEAR/HOLD logic is generated.

## Structure
- Package upctr_sched_pkg holds:
  - op_e enum: OP_INC, OP_ROL, OP_CLEAR, OP_HOLD
  - state_e enum: IDLE, RUN, DONE
  - requester id constants REQ_A = 0, REQ_B = 1
- One sub-module, upctr_step: combinational next-value function (op, value) -> next_value, covering INC, ROL and, under UPCTR_SCHED_CLEAR_EN, CLEAR/HOLD.
- upctr_sched owns the FSM, arbiter, count register and state register.

## Test plan
- After reset, A issues INC cnt=3 -> a_ready high in the same cycle; value goes 1, 2, 3 on consecutive edges; done_valid one cycle later with done_id=0, done_value=0x03.
- value=0xFE, B issues INC cnt=2 -> value 0xFF then 0x00 (wrap); done_value=0x00, done_id=1.
- value=0x81, A issues ROL cnt=1 -> value 0x03; done 2 cycles after acceptance.
- A and B both valid from reset -> A granted first, B granted at the next IDLE; with both held continuously, grants alternate A, B, A.
- A issues INC cnt=0 -> done_valid after 1 cycle with value unchanged; busy high for exactly 1 cycle.
- Assert rst=0 during RUN of INC cnt=10 after 4 steps -> next cycle value=0, busy=0, and no done_valid pulse ever appears for that command. With UPCTR_SCHED_CLEAR_EN: CLEAR cnt=7 from value 0x55 -> 0x00 after one RUN cycle, done 2 cycles after acceptance.
